// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count sequencer and its phase timer.
package count_seq_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int REP_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN_A = 3'd1,
    SWAP1 = 3'd2,
    RUN_B = 3'd3,
    SWAP2 = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/seq_len_timer.sv
// Loadable phase-length down-counter; o_tc flags the last counted cycle of a phase.
module seq_len_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_len,
  input  logic         i_dec,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  // Terminal count at 1 so the phase ends after exactly i_len enabled cycles.
  assign o_tc = (r_cnt == W'(1));

endmodule

// File: rtl/count_sequencer.sv
// Up/down counter sequencer: Reps round trips of UpLen enables, swap, DownLen enables, swap.
//
// state | meaning
// IDLE  | waiting for Start with nonzero Reps
// RUN_A | Enable high for the latched UpLen cycles
// SWAP1 | one-cycle Swap pulse between phases
// RUN_B | Enable high for the latched DownLen cycles
// SWAP2 | one-cycle Swap pulse, round trip finished, RepsLeft decrements
// DONE  | one-cycle Done pulse after the last round trip
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Start,
  input  logic             Abort,
  input  logic [LEN_W-1:0] UpLen,
  input  logic [LEN_W-1:0] DownLen,
  input  logic [REP_W-1:0] Reps,
  output logic             Enable,
  output logic             Swap,
  output logic             Busy,
  output logic             Done,
  output logic [REP_W-1:0] RepsLeft
);

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_up;
  logic [LEN_W-1:0] r_dn;
  logic [REP_W-1:0] r_reps;
  logic [LEN_W-1:0] w_load_val;
  logic             w_load;
  logic             w_accept;
  logic             w_dec_reps;
  logic             w_tc;
  logic             w_abort;

  assign w_abort = Abort && (r_state != IDLE);

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = r_up;
    w_accept   = 1'b0;
    w_dec_reps = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start && (Reps != '0)) begin
          w_accept = 1'b1;
          // Latched copies are not valid yet, so load the timer straight from the inputs.
          if (UpLen != '0) begin
            w_next     = RUN_A;
            w_load     = 1'b1;
            w_load_val = UpLen;
          end else begin
            w_next = SWAP1;
          end
        end
      end
      RUN_A: if (w_tc) w_next = SWAP1;
      SWAP1: begin
        if (r_dn != '0) begin
          w_next     = RUN_B;
          w_load     = 1'b1;
          w_load_val = r_dn;
        end else begin
          w_next = SWAP2;
        end
      end
      RUN_B: if (w_tc) w_next = SWAP2;
      SWAP2: begin
        w_dec_reps = 1'b1;
        if (r_reps != REP_W'(1)) begin
          if (r_up != '0) begin
            w_next     = RUN_A;
            w_load     = 1'b1;
            w_load_val = r_up;
          end else begin
            w_next = SWAP1;
          end
        end else begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) begin
      w_next     = IDLE;
      w_load     = 1'b0;
      w_dec_reps = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_up   <= '0;
      r_dn   <= '0;
      r_reps <= '0;
    end else if (w_accept) begin
      r_up   <= UpLen;
      r_dn   <= DownLen;
      r_reps <= Reps;
    end else if (w_dec_reps) begin
      r_reps <= r_reps - REP_W'(1);
    end
  end

  seq_len_timer #(.W(LEN_W)) u_timer (
    .i_clk   (Clock),
    .i_rst_n (ResetN),
    .i_load  (w_load),
    .i_len   (w_load_val),
    .i_dec   (Enable),
    .o_tc    (w_tc)
  );

  assign Enable   = (r_state == RUN_A) || (r_state == RUN_B);
  assign Swap     = (r_state == SWAP1) || (r_state == SWAP2);
  assign Busy     = (r_state != IDLE);
  assign Done     = (r_state == DONE);
  assign RepsLeft = r_reps;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: timeline model of expected per-cycle outputs plus literal phase counts.
module tb_count_sequencer;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b1;
  logic       Start = 1'b0;
  logic       Abort = 1'b0;
  logic [3:0] UpLen = 4'd0;
  logic [3:0] DownLen = 4'd0;
  logic [3:0] Reps = 4'd0;
  logic       Enable, Swap, Busy, Done;
  logic [3:0] RepsLeft;

  count_sequencer #(.LEN_W(4), .REP_W(4)) dut (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .Start    (Start),
    .Abort    (Abort),
    .UpLen    (UpLen),
    .DownLen  (DownLen),
    .Reps     (Reps),
    .Enable   (Enable),
    .Swap     (Swap),
    .Busy     (Busy),
    .Done     (Done),
    .RepsLeft (RepsLeft)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       en;
    logic       sw;
    logic       busy;
    logic       done;
    logic [3:0] rl;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   cnt_busy = 0, cnt_en = 0, cnt_sw = 0, cnt_done = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // Expected timeline: each accepted Start expands into the full list of cycles it produces.
  always @(posedge Clock or negedge ResetN) begin
    exp_t e;
    if (!ResetN) begin
      q.delete();
      cur = '0;
    end else if (cur.busy && Abort) begin
      q.delete();
      cur.en = 1'b0; cur.sw = 1'b0; cur.busy = 1'b0; cur.done = 1'b0;
    end else if (!cur.busy) begin
      if (Start && (Reps != 4'd0)) begin
        for (int k = 0; k < int'(Reps); k++) begin
          e = '0;
          e.busy = 1'b1;
          e.rl = 4'(int'(Reps) - k);
          e.en = 1'b1; e.sw = 1'b0;
          for (int i = 0; i < int'(UpLen); i++) q.push_back(e);
          e.en = 1'b0; e.sw = 1'b1;
          q.push_back(e);
          e.en = 1'b1; e.sw = 1'b0;
          for (int i = 0; i < int'(DownLen); i++) q.push_back(e);
          e.en = 1'b0; e.sw = 1'b1;
          q.push_back(e);
        end
        e = '0;
        e.busy = 1'b1; e.done = 1'b1; e.rl = 4'd0;
        q.push_back(e);
        cur = q.pop_front();
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur.en = 1'b0; cur.sw = 1'b0; cur.busy = 1'b0; cur.done = 1'b0;
    end
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("enable", int'(Enable), int'(cur.en));
      chk("swap", int'(Swap), int'(cur.sw));
      chk("busy", int'(Busy), int'(cur.busy));
      chk("done", int'(Done), int'(cur.done));
      chk("repsleft", int'(RepsLeft), int'(cur.rl));
      chk("enable_swap_exclusive", int'(Enable & Swap), 0);
      cnt_busy += int'(Busy);
      cnt_en   += int'(Enable);
      cnt_sw   += int'(Swap);
      cnt_done += int'(Done);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic start_seq(input int u, input int d, input int r);
    UpLen = 4'(u); DownLen = 4'(d); Reps = 4'(r);
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic run_seq(input string nm, input int u, input int d, input int r,
                         input int eb, input int ee, input int es, input int ed);
    int b0, e0, s0, d0;
    b0 = cnt_busy; e0 = cnt_en; s0 = cnt_sw; d0 = cnt_done;
    start_seq(u, d, r);
    repeat (24) tick();
    chk({nm, "_busy_cycles"}, cnt_busy - b0, eb);
    chk({nm, "_enable_cycles"}, cnt_en - e0, ee);
    chk({nm, "_swap_cycles"}, cnt_sw - s0, es);
    chk({nm, "_done_cycles"}, cnt_done - d0, ed);
  endtask

  initial begin
    int b0, e0, s0, d0;
    #3 ResetN = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_busy", int'(Busy), 0);
    chk("reset_repsleft", int'(RepsLeft), 0);
    repeat (3) @(posedge Clock);
    #2 ResetN = 1'b1;
    tick();

    run_seq("u3d2r1", 3, 2, 1, 8, 5, 2, 1);
    run_seq("u3d2r2", 3, 2, 2, 15, 10, 4, 1);
    run_seq("u0d2r1", 0, 2, 1, 5, 2, 2, 1);
    run_seq("u15d1r1", 15, 1, 1, 19, 16, 2, 1);
    run_seq("u0d0r2", 0, 0, 2, 5, 0, 4, 1);
    run_seq("u1d0r3", 1, 0, 3, 10, 3, 6, 1);

    run_seq("reps0", 3, 2, 0, 0, 0, 0, 0);

    // Second Start mid-sequence with different values must not disturb the first.
    b0 = cnt_busy; e0 = cnt_en; s0 = cnt_sw; d0 = cnt_done;
    start_seq(3, 2, 1);
    tick();
    UpLen = 4'd7; DownLen = 4'd7; Reps = 4'd5; Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (20) tick();
    chk("restart_busy_cycles", cnt_busy - b0, 8);
    chk("restart_enable_cycles", cnt_en - e0, 5);
    chk("restart_swap_cycles", cnt_sw - s0, 2);
    chk("restart_done_cycles", cnt_done - d0, 1);

    // Abort during the second RUN_B cycle.
    b0 = cnt_busy; e0 = cnt_en; s0 = cnt_sw; d0 = cnt_done;
    start_seq(3, 2, 1);
    repeat (5) tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_busy_now", int'(Busy), 0);
    repeat (10) tick();
    chk("abort_busy_cycles", cnt_busy - b0, 6);
    chk("abort_enable_cycles", cnt_en - e0, 5);
    chk("abort_swap_cycles", cnt_sw - s0, 1);
    chk("abort_done_cycles", cnt_done - d0, 0);
    chk("abort_repsleft_hold", int'(RepsLeft), 1);

    b0 = cnt_busy;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    repeat (3) tick();
    chk("idle_abort_busy_cycles", cnt_busy - b0, 0);
    run_seq("after_abort", 3, 2, 1, 8, 5, 2, 1);

    // Asynchronous reset in the middle of RUN_A.
    start_seq(5, 2, 3);
    tick();
    #1 ResetN = 1'b0;
    #1;
    chk("async_reset_enable", int'(Enable), 0);
    chk("async_reset_busy", int'(Busy), 0);
    chk("async_reset_repsleft", int'(RepsLeft), 0);
    tick();
    ResetN = 1'b1;
    b0 = cnt_busy;
    repeat (6) tick();
    chk("post_reset_idle_cycles", cnt_busy - b0, 0);
    run_seq("post_reset", 3, 2, 1, 8, 5, 2, 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL provide parameter LEN_W, default 4: width of the run-length inputs, matching the 4-bit counter datapath.
REQ-002 SHALL provide parameter REP_W, default 4: width of the repetition-count input.
REQ-003 SHALL have port Clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ResetN, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1: single-cycle request to begin a sequence.
REQ-006 SHALL have port Abort, input, 1: terminate any sequence in progress.
REQ-007 SHALL have port UpLen, input, LEN_W: number of Enable cycles in phase A.
REQ-008 SHALL have port DownLen, input, LEN_W: number of Enable cycles in phase B.
REQ-009 SHALL have port Reps, input, REP_W: number of A/B round trips.
REQ-010 SHALL have port Enable, output, 1: count-enable to the up/down counter.
REQ-011 SHALL have port Swap, output, 1: one-cycle direction-swap pulse to the counter.
REQ-012 SHALL have port Busy, output, 1: high whenever the state is not IDLE.
REQ-013 SHALL have port Done, output, 1: one-cycle pulse on normal completion.
REQ-014 SHALL have port RepsLeft, output, REP_W: round trips remaining, including the current one.

Function
REQ-015 SHALL implement the states IDLE, RUN_A, SWAP1, RUN_B, SWAP2 and DONE, with all outputs decoded from registered state (Moore).
REQ-016 In IDLE, a sampled Start with Reps != 0 SHALL latch UpLen, DownLen and Reps, then move to RUN_A, or to SWAP1 if UpLen == 0; Enable rises in the cycle after the Start edge.
REQ-017 In IDLE, Start with Reps == 0 SHALL be ignored; Start while Busy SHALL be ignored and SHALL leave the latched values unchanged.
REQ-018 RUN_A SHALL hold Enable=1 for exactly the latched UpLen cycles, then go to SWAP1.
REQ-019 SWAP1 SHALL assert Swap=1 and Enable=0 for one cycle, then go to RUN_B, or directly to SWAP2 if DownLen == 0.
REQ-020 RUN_B SHALL hold Enable=1 for exactly the latched DownLen cycles, then go to SWAP2.
REQ-021 SWAP2 SHALL assert Swap=1 for one cycle and decrement RepsLeft; if the result is nonzero, go to RUN_A (or to SWAP1 if UpLen == 0); otherwise go to DONE.
REQ-022 DONE SHALL assert Done=1 for one cycle, then go to IDLE.
REQ-023 Enable and Swap SHALL never be high in the same cycle.
REQ-024 Swap pulses SHALL always occur in pairs on normal completion, so that the counter's orientation is restored.
REQ-025 Abort sampled in any non-IDLE state SHALL force IDLE on the next edge, with no Swap and no Done pulse.
REQ-026 Abort SHALL take priority over Start and over completion; Abort in IDLE SHALL have no effect.
REQ-027 Run-length counting SHALL be modulo-free: lengths of 1..2^LEN_W-1 are exact, and a zero length skips its phase.
REQ-028 RepsLeft SHALL hold its value in IDLE and SHALL reload only on an accepted Start.

Reset
REQ-029 ResetN low SHALL immediately (asynchronously) force IDLE, Enable=0, Swap=0, Busy=0, Done=0, RepsLeft=0 and clear the latched lengths.
REQ-030 Reset asserted mid-sequence SHALL discard the sequence; after ResetN rises, the block SHALL wait in IDLE for a new Start.

Structure
REQ-031 Package count_seq_pkg SHALL hold the state enumeration and the default LEN_W and REP_W constants.
REQ-032 The phase-length timer SHALL be a sub-module, seq_len_timer: a loadable down-counter with a terminal-count flag, instantiated once and reloaded per phase.

Verification
REQ-033 UpLen=3, DownLen=2, Reps=1, Start -> Enable high for 3 cycles, Swap for 1, Enable for 2, Swap for 1, Done for 1; Busy high for 8 cycles total.
REQ-034 UpLen=3, DownLen=2, Reps=2 -> Busy for 15 cycles; RepsLeft reads 2 then 1; Done pulses once at the end.
REQ-035 UpLen=0, DownLen=2, Reps=1 -> Swap, Enable for 2 cycles, Swap, Done; Busy for 5 cycles.
REQ-036 Abort asserted in the 2nd RUN_B cycle -> next cycle IDLE, Busy=0, no further Swap, no Done.
REQ-037 Start with Reps=0, and Start re-asserted while Busy -> both ignored; the in-flight sequence timing is unchanged.
REQ-038 ResetN pulled low mid-RUN_A, asynchronous to Clock -> Enable and Busy go 0 without waiting for a Clock edge; RepsLeft=0.
